// File: rtl/conv2_mem_read_if.sv
// Conv2 read-side address bus: enable in, tap addresses and strobes out.
// slave  : the address generator (conv2_mem_read)
// master : the consumer that drives enable and reads the tap stream
interface conv2_mem_read_if;
  logic       enable;
  logic [7:0] img_addr;
  logic [4:0] wt_addr;
  logic [1:0] filt;
  logic [5:0] out_addr;
  logic       valid;
  logic       first;
  logic       last;
  logic       bias_valid;
  logic       done;

  modport slave (
    input  enable,
    output img_addr, wt_addr, filt, out_addr,
    output valid, first, last, bias_valid, done
  );

  modport master (
    output enable,
    input  img_addr, wt_addr, filt, out_addr,
    input  valid, first, last, bias_valid, done
  );
endinterface

// File: rtl/conv2_mem_read.sv
// Conv2 read-side address generator: walks a 12x12 input map with a 5x5
// window for each of 3 filters, one tap per enabled cycle.
// Optional feature macro: CONV2_RD_BIAS_EN adds one bias cycle per window.
module conv2_mem_read #(
  parameter int IMG_W    = 12,
  parameter int K        = 5,
  parameter int OUT_W    = 8,
  parameter int NUM_FILT = 3
) (
  input logic             clk,
  input logic             reset,
  conv2_mem_read_if.slave bus
);
  localparam int KW = $clog2(K);
  localparam int OW = $clog2(OUT_W);

`ifdef CONV2_RD_BIAS_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2, S_BIAS = 2'd3} state_e;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_e;
`endif

  state_e          r_state, w_next;
  logic [KW-1:0]   r_kc, r_kr, w_kc_n, w_kr_n;
  logic [OW-1:0]   r_ocol, r_orow, w_ocol_n, w_orow_n;
  logic [1:0]      r_filt, w_filt_n;
  logic [7:0]      r_img_addr, w_img_n, w_row_n;
  logic [4:0]      r_wt_addr, w_wt_n;
  logic [5:0]      r_out_addr, w_out_n;
  logic            w_advance, w_valid, w_done;
  logic            w_tap_last, w_final;
`ifdef CONV2_RD_BIAS_EN
  logic            w_bias;
`endif

  assign w_tap_last = (r_kc == KW'(K - 1)) && (r_kr == KW'(K - 1));
  assign w_final    = w_tap_last && (r_ocol == OW'(OUT_W - 1)) &&
                      (r_orow == OW'(OUT_W - 1)) && (r_filt == 2'(NUM_FILT - 1));

  // State register; reset wins over enable.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next state, tap issue and counter-advance decision.
  always_comb begin
    w_next    = r_state;
    w_advance = 1'b0;
    w_valid   = 1'b0;
    w_done    = 1'b0;
`ifdef CONV2_RD_BIAS_EN
    w_bias    = 1'b0;
`endif
    case (r_state)
      S_IDLE: if (bus.enable) w_next = S_RUN;
      S_RUN: begin
        w_valid = bus.enable;
        if (bus.enable) begin
`ifdef CONV2_RD_BIAS_EN
          // Window advance is deferred until the bias cycle has been taken.
          if (w_tap_last) w_next = S_BIAS;
          else            w_advance = 1'b1;
`else
          // Counters hold their final values once the frame is complete.
          if (w_final) w_next = S_DONE;
          else         w_advance = 1'b1;
`endif
        end
      end
`ifdef CONV2_RD_BIAS_EN
      S_BIAS: begin
        w_bias = bus.enable;
        if (bus.enable) begin
          if (w_final) w_next = S_DONE;
          else begin
            w_advance = 1'b1;
            w_next    = S_RUN;
          end
        end
      end
`endif
      S_DONE:  w_done = 1'b1;
      default: w_next = S_IDLE;
    endcase
  end

  // Nested wrap-around of kc -> kr -> ocol -> orow -> filt, and the
  // addresses those next counter values select.
  always_comb begin
    w_kc_n   = r_kc;
    w_kr_n   = r_kr;
    w_ocol_n = r_ocol;
    w_orow_n = r_orow;
    w_filt_n = r_filt;
    if (w_advance) begin
      if (r_kc != KW'(K - 1)) w_kc_n = r_kc + 1'b1;
      else begin
        w_kc_n = '0;
        if (r_kr != KW'(K - 1)) w_kr_n = r_kr + 1'b1;
        else begin
          w_kr_n = '0;
          if (r_ocol != OW'(OUT_W - 1)) w_ocol_n = r_ocol + 1'b1;
          else begin
            w_ocol_n = '0;
            if (r_orow != OW'(OUT_W - 1)) w_orow_n = r_orow + 1'b1;
            else begin
              w_orow_n = '0;
              w_filt_n = r_filt + 1'b1;
            end
          end
        end
      end
    end
    w_row_n = 8'(w_orow_n) + 8'(w_kr_n);
    w_img_n = w_row_n * 8'(IMG_W) + 8'(w_ocol_n) + 8'(w_kc_n);
    w_wt_n  = 5'(w_kr_n) * 5'(K) + 5'(w_kc_n);
    w_out_n = 6'(w_orow_n) * 6'(OUT_W) + 6'(w_ocol_n);
  end

  // Counters and registered addresses move together on each consumed tap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_kc       <= '0;
      r_kr       <= '0;
      r_ocol     <= '0;
      r_orow     <= '0;
      r_filt     <= '0;
      r_img_addr <= '0;
      r_wt_addr  <= '0;
      r_out_addr <= '0;
    end else if (w_advance) begin
      r_kc       <= w_kc_n;
      r_kr       <= w_kr_n;
      r_ocol     <= w_ocol_n;
      r_orow     <= w_orow_n;
      r_filt     <= w_filt_n;
      r_img_addr <= w_img_n;
      r_wt_addr  <= w_wt_n;
      r_out_addr <= w_out_n;
    end
  end

  assign bus.img_addr = r_img_addr;
  assign bus.wt_addr  = r_wt_addr;
  assign bus.filt     = r_filt;
  assign bus.out_addr = r_out_addr;
  assign bus.valid    = w_valid;
  assign bus.first    = w_valid && (r_kc == '0) && (r_kr == '0);
  assign bus.last     = w_valid && w_tap_last;
  assign bus.done     = w_done;
`ifdef CONV2_RD_BIAS_EN
  assign bus.bias_valid = w_bias;
`else
  assign bus.bias_valid = 1'b0;
`endif
endmodule

// File: tb/tb_conv2_mem_read.sv
// Bench for conv2_mem_read: table-driven start-of-frame vectors, hand-written
// corner sequences and a random-enable run, all against a tap-index model.
module tb_conv2_mem_read;
  localparam int IMG_W    = 12;
  localparam int K        = 5;
  localparam int OUT_W    = 8;
  localparam int NUM_FILT = 3;
  localparam int WIN      = K * K;
  localparam int TAPS     = NUM_FILT * OUT_W * OUT_W * WIN;
  localparam int NWIN     = TAPS / WIN;
`ifdef CONV2_RD_BIAS_EN
  localparam bit BIAS = 1'b1;
`else
  localparam bit BIAS = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  conv2_mem_read_if bus ();

  conv2_mem_read #(
    .IMG_W(IMG_W), .K(K), .OUT_W(OUT_W), .NUM_FILT(NUM_FILT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic [7:0] img;
    logic [4:0] wt;
    logic [1:0] filt;
    logic [5:0] out;
    logic       valid;
    logic       first;
    logic       last;
    logic       bias;
    logic       done;
  } obs_t;

  typedef enum int {M_IDLE, M_RUN, M_BIAS, M_DONE} mph_e;

  int   checks = 0;
  int   errors = 0;
  mph_e m_ph   = M_IDLE;
  int   m_t    = 0;
  int   cyc;
  int   n_valid, n_first, n_last, n_bias;
  int   last_valid_cyc, first_done_cyc;
  obs_t last_obs;
  obs_t snap [32];
  logic [7:0] tap_img  [TAPS];
  logic [4:0] tap_wt   [TAPS];
  logic [1:0] tap_filt [TAPS];
  logic [5:0] tap_out  [TAPS];

  function automatic obs_t observe();
    obs_t o;
    o.img   = bus.img_addr;
    o.wt    = bus.wt_addr;
    o.filt  = bus.filt;
    o.out   = bus.out_addr;
    o.valid = bus.valid;
    o.first = bus.first;
    o.last  = bus.last;
    o.bias  = bus.bias_valid;
    o.done  = bus.done;
    return o;
  endfunction

  // Expected outputs from the tap index: decompose into loop positions.
  function automatic obs_t model_exp(input logic en);
    obs_t e;
    int kc, kr, oc, orw, f;
    kc  = m_t % K;
    kr  = (m_t / K) % K;
    oc  = (m_t / WIN) % OUT_W;
    orw = (m_t / (WIN * OUT_W)) % OUT_W;
    f   = m_t / (WIN * OUT_W * OUT_W);
    e.img   = 8'((orw + kr) * IMG_W + oc + kc);
    e.wt    = 5'(kr * K + kc);
    e.filt  = 2'(f);
    e.out   = 6'(orw * OUT_W + oc);
    e.valid = (m_ph == M_RUN) && en;
    e.first = e.valid && (m_t % WIN == 0);
    e.last  = e.valid && (m_t % WIN == WIN - 1);
    e.bias  = (m_ph == M_BIAS) && en;
    e.done  = (m_ph == M_DONE);
    return e;
  endfunction

  task automatic model_edge(input logic en, input logic rst);
    if (rst) begin
      m_ph = M_IDLE;
      m_t  = 0;
    end else begin
      case (m_ph)
        M_IDLE: if (en) m_ph = M_RUN;
        M_RUN: if (en) begin
          if (BIAS && (m_t % WIN == WIN - 1)) m_ph = M_BIAS;
          else if (m_t == TAPS - 1)           m_ph = M_DONE;
          else                                m_t++;
        end
        M_BIAS: if (en) begin
          if (m_t == TAPS - 1) m_ph = M_DONE;
          else begin
            m_t++;
            m_ph = M_RUN;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic clear_stats();
    cyc = 0; n_valid = 0; n_first = 0; n_last = 0; n_bias = 0;
    last_valid_cyc = -1; first_done_cyc = -1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.enable = 1'b0;
    @(posedge clk);
    model_edge(1'b0, 1'b1);
    clear_stats();
  endtask

  // One clock: drive, compare against the model mid-cycle, then advance model.
  task automatic step(input logic en, input logic rst);
    obs_t a, e;
    @(negedge clk);
    bus.enable = en;
    reset      = rst;
    #1;
    a = observe();
    e = model_exp(en);
    checks++;
    if (a !== e) begin
      errors++;
      if (errors <= 20)
        $display("FAIL model cyc%0d: got %h expected %h", cyc, a, e);
    end
    last_obs = a;
    if (a.valid === 1'b1) begin
      if (n_valid < TAPS) begin
        tap_img[n_valid]  = a.img;
        tap_wt[n_valid]   = a.wt;
        tap_filt[n_valid] = a.filt;
        tap_out[n_valid]  = a.out;
      end
      n_valid++;
      last_valid_cyc = cyc;
    end
    if (a.first === 1'b1) n_first++;
    if (a.last  === 1'b1) n_last++;
    if (a.bias  === 1'b1) n_bias++;
    if (a.done === 1'b1 && first_done_cyc < 0) first_done_cyc = cyc;
    @(posedge clk);
    model_edge(en, rst);
    cyc++;
  endtask

  typedef struct {
    int         c;
    logic [7:0] img;
    logic [4:0] wt;
    logic [5:0] out;
    logic       valid;
    logic       first;
    logic       last;
    logic       bias;
  } vec_t;

  vec_t vt [6];

  initial begin
    reset      = 1'b1;
    bus.enable = 1'b0;

`ifdef CONV2_RD_BIAS_EN
    vt[0] = '{c: 1,  img: 8'd0,  wt: 5'd0,  out: 6'd0, valid: 1'b1, first: 1'b1, last: 1'b0, bias: 1'b0};
    vt[1] = '{c: 5,  img: 8'd4,  wt: 5'd4,  out: 6'd0, valid: 1'b1, first: 1'b0, last: 1'b0, bias: 1'b0};
    vt[2] = '{c: 6,  img: 8'd12, wt: 5'd5,  out: 6'd0, valid: 1'b1, first: 1'b0, last: 1'b0, bias: 1'b0};
    vt[3] = '{c: 25, img: 8'd52, wt: 5'd24, out: 6'd0, valid: 1'b1, first: 1'b0, last: 1'b1, bias: 1'b0};
    vt[4] = '{c: 26, img: 8'd52, wt: 5'd24, out: 6'd0, valid: 1'b0, first: 1'b0, last: 1'b0, bias: 1'b1};
    vt[5] = '{c: 27, img: 8'd1,  wt: 5'd0,  out: 6'd1, valid: 1'b1, first: 1'b1, last: 1'b0, bias: 1'b0};
`else
    vt[0] = '{c: 0,  img: 8'd0,  wt: 5'd0,  out: 6'd0, valid: 1'b0, first: 1'b0, last: 1'b0, bias: 1'b0};
    vt[1] = '{c: 1,  img: 8'd0,  wt: 5'd0,  out: 6'd0, valid: 1'b1, first: 1'b1, last: 1'b0, bias: 1'b0};
    vt[2] = '{c: 5,  img: 8'd4,  wt: 5'd4,  out: 6'd0, valid: 1'b1, first: 1'b0, last: 1'b0, bias: 1'b0};
    vt[3] = '{c: 6,  img: 8'd12, wt: 5'd5,  out: 6'd0, valid: 1'b1, first: 1'b0, last: 1'b0, bias: 1'b0};
    vt[4] = '{c: 25, img: 8'd52, wt: 5'd24, out: 6'd0, valid: 1'b1, first: 1'b0, last: 1'b1, bias: 1'b0};
    vt[5] = '{c: 26, img: 8'd1,  wt: 5'd0,  out: 6'd1, valid: 1'b1, first: 1'b1, last: 1'b0, bias: 1'b0};
`endif

    // Frame start with enable held high; cycle 0 is the IDLE cycle.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      step(1'b1, 1'b0);
      snap[i] = last_obs;
    end
    chk("reset_idle_valid", {31'd0, snap[0].valid}, 32'd0);
    chk("reset_idle_img",   {24'd0, snap[0].img},   32'd0);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("vec_c%0d_img",   vt[i].c), {24'd0, snap[vt[i].c].img},   {24'd0, vt[i].img});
      chk($sformatf("vec_c%0d_wt",    vt[i].c), {27'd0, snap[vt[i].c].wt},    {27'd0, vt[i].wt});
      chk($sformatf("vec_c%0d_out",   vt[i].c), {26'd0, snap[vt[i].c].out},   {26'd0, vt[i].out});
      chk($sformatf("vec_c%0d_valid", vt[i].c), {31'd0, snap[vt[i].c].valid}, {31'd0, vt[i].valid});
      chk($sformatf("vec_c%0d_first", vt[i].c), {31'd0, snap[vt[i].c].first}, {31'd0, vt[i].first});
      chk($sformatf("vec_c%0d_last",  vt[i].c), {31'd0, snap[vt[i].c].last},  {31'd0, vt[i].last});
      chk($sformatf("vec_c%0d_bias",  vt[i].c), {31'd0, snap[vt[i].c].bias},  {31'd0, vt[i].bias});
    end

    // Full frame with enable high.
    do_reset();
    for (int i = 0; i < 6000 && m_ph != M_DONE; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("frame_done",        {31'd0, last_obs.done}, 32'd1);
    chk("frame_valid_count", n_valid, TAPS);
    chk("frame_first_count", n_first, NWIN);
    chk("frame_last_count",  n_last,  NWIN);
    chk("frame_bias_count",  n_bias,  BIAS ? NWIN : 0);
    chk("frame_last_tap_cyc", last_valid_cyc, TAPS + (BIAS ? NWIN - 1 : 0));
    chk("frame_done_rise",   first_done_cyc, last_valid_cyc + (BIAS ? 2 : 1));
    chk("tap1599_img",  {24'd0, tap_img[1599]},  32'd143);
    chk("tap1599_wt",   {27'd0, tap_wt[1599]},   32'd24);
    chk("tap1599_out",  {26'd0, tap_out[1599]},  32'd63);
    chk("tap1599_filt", {30'd0, tap_filt[1599]}, 32'd0);
    chk("tap1600_img",  {24'd0, tap_img[1600]},  32'd0);
    chk("tap1600_out",  {26'd0, tap_out[1600]},  32'd0);
    chk("tap1600_filt", {30'd0, tap_filt[1600]}, 32'd1);
    chk("tap4799_img",  {24'd0, tap_img[4799]},  32'd143);
    for (int i = 0; i < 6; i++) begin
      step(logic'(i % 2), 1'b0);
      chk("done_sticky",   {31'd0, last_obs.done},  32'd1);
      chk("done_no_valid", {31'd0, last_obs.valid}, 32'd0);
    end

    // Three-cycle enable gap after the 10th tap of window 1 (tap 34).
    do_reset();
    for (int i = 0; i < 200 && !(m_ph == M_RUN && m_t == 34); i++) step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("gap_tap10_img",   {24'd0, last_obs.img},   32'd17);
    chk("gap_tap10_wt",    {27'd0, last_obs.wt},    32'd9);
    chk("gap_tap10_valid", {31'd0, last_obs.valid}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0);
      chk("gap_hold_img",   {24'd0, last_obs.img},   32'd25);
      chk("gap_hold_wt",    {27'd0, last_obs.wt},    32'd10);
      chk("gap_hold_valid", {31'd0, last_obs.valid}, 32'd0);
    end
    step(1'b1, 1'b0);
    chk("gap_resume_img",   {24'd0, last_obs.img},   32'd25);
    chk("gap_resume_wt",    {27'd0, last_obs.wt},    32'd10);
    chk("gap_resume_valid", {31'd0, last_obs.valid}, 32'd1);
    chk("gap_resume_first", {31'd0, last_obs.first}, 32'd0);

    // Reset at tap 2000 with enable high.
    do_reset();
    for (int i = 0; i < 3000 && !(m_ph == M_RUN && m_t == 2000); i++) step(1'b1, 1'b0);
    chk("pre_rst_valid", {31'd0, bus.valid}, 32'd1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    chk("mid_rst_all_zero", {6'd0, last_obs}, 32'd0);
    step(1'b1, 1'b0);
    chk("restart_img",   {24'd0, last_obs.img},   32'd0);
    chk("restart_first", {31'd0, last_obs.first}, 32'd1);

    // Random enable over a complete frame.
    do_reset();
    for (int i = 0; i < 20000 && m_ph != M_DONE; i++)
      step(logic'($urandom_range(0, 9) < 7), 1'b0);
    step(1'b1, 1'b0);
    chk("rand_done",        {31'd0, last_obs.done}, 32'd1);
    chk("rand_valid_count", n_valid, TAPS);
    chk("rand_first_count", n_first, NWIN);
    chk("rand_last_count",  n_last,  NWIN);
    for (int i = 0; i < 8; i++) step(logic'($urandom_range(0, 1)), 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
